// File: rtl/instr_encoder_if.sv
// ----------------------------------------------------------------------------
// instr_encoder_if
// Record stream and instruction-memory write port of the instruction encoder.
//   in_valid/in_ready  : record handshake (accepted when both are high)
//   in_class/in_op     : format class and op select within the class
//   in_rs/in_rt/in_rd  : register fields
//   in_imm             : immediate (R class uses in_imm[4:0] as shamt)
//   in_last            : final record of the load session
//   wr_en/wr_addr/wr_data : instruction memory write strobe, word address, word
// Modports: master drives records and observes the write port; slave is the
// encoder.
// ----------------------------------------------------------------------------
interface instr_encoder_if #(
  parameter int ADDR_W = 6
);
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_class;
  logic [1:0]        in_op;
  logic [4:0]        in_rs;
  logic [4:0]        in_rt;
  logic [4:0]        in_rd;
  logic [15:0]       in_imm;
  logic              in_last;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;

  modport master (
    output in_valid, in_class, in_op, in_rs, in_rt, in_rd, in_imm, in_last,
    input  in_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  in_valid, in_class, in_op, in_rs, in_rt, in_rd, in_imm, in_last,
    output in_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/instr_encoder.sv
// ----------------------------------------------------------------------------
// instr_encoder
// Builds 32-bit MIPS instruction words from field-level records and writes
// them to sequential instruction-memory addresses during a load session.
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high reset
//   start      begins a load session (only honoured while idle)
//   bus        instr_encoder_if.slave: record stream in, memory write port out
//   busy       high while accepting records or flushing the last write
//   done       one-cycle pulse when the session completes
//   overflow   sticky: session ended because capacity was reached
//   err_count  rejected records this session, saturating at 255
// Build option: define ENC_NOP_FILL_EN to have invalid records write a NOP
// (32'h00000000) so memory addresses stay aligned with record order;
// otherwise invalid records are dropped without a write.
// ----------------------------------------------------------------------------
module instr_encoder #(
  parameter int ADDR_W    = 6,
  parameter int BASE_ADDR = 0,
  parameter int MAX_WORDS = 64
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  instr_encoder_if.slave bus,
  output logic           busy,
  output logic           done,
  output logic           overflow,
  output logic [7:0]     err_count
);

  localparam int                CNT_W   = $clog2(MAX_WORDS + 1);
  localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);
  localparam logic [CNT_W-1:0]  MAX_CNT = CNT_W'(MAX_WORDS);
`ifdef ENC_NOP_FILL_EN
  localparam logic NOP_FILL = 1'b1;
`else
  localparam logic NOP_FILL = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_FLUSH = 2'b10,
    S_DONE  = 2'b11
  } state_t;

  state_t            state_r, state_n;
  logic [ADDR_W-1:0] addr_r;      // next address to be written
  logic [CNT_W-1:0]  count_r;     // words written this session
  logic [7:0]        err_r;
  logic              ovf_r;
  logic              wr_en_r;
  logic [ADDR_W-1:0] wr_addr_r;
  logic [31:0]       wr_data_r;
  logic              in_ready_r;
  logic              busy_r;
  logic              done_r;

  logic              rec_ok_s;
  logic              accept_s;
  logic              write_s;
  logic              cap_hit_s;
  logic              ending_s;
  logic [31:0]       word_s;

  // Class 11 and op 3 in any class have no encoding.
  function automatic logic rec_valid(input logic [1:0] cls, input logic [1:0] op);
    return (cls != 2'b11) && (op != 2'b11);
  endfunction

  function automatic logic [31:0] encode_word(
    input logic [1:0]  cls,
    input logic [1:0]  op,
    input logic [4:0]  rs,
    input logic [4:0]  rt,
    input logic [4:0]  rd,
    input logic [15:0] imm
  );
    logic [5:0] code;
    logic [31:0] word;
    code = 6'b000000;
    word = 32'h0000_0000;
    case (cls)
      2'b00: begin
        case (op)
          2'b00:   code = 6'b000000;  // sll
          2'b01:   code = 6'b000010;  // srl
          2'b10:   code = 6'b000011;  // sra
          default: code = 6'b000000;
        endcase
        word = {6'b000000, rs, rt, rd, imm[4:0], code};
      end
      2'b01: begin
        case (op)
          2'b00:   code = 6'b001000;  // addi
          2'b01:   code = 6'b100011;  // lw
          2'b10:   code = 6'b101011;  // sw
          default: code = 6'b000000;
        endcase
        word = {code, rs, rt, imm};
      end
      2'b10: begin
        case (op)
          2'b00:   code = 6'b001100;  // andi
          2'b01:   code = 6'b001101;  // ori
          2'b10:   code = 6'b001110;  // xori
          default: code = 6'b000000;
        endcase
        word = {code, rs, rt, imm};
      end
      default: word = 32'h0000_0000;
    endcase
    return word;
  endfunction

  // Record acceptance, write decision and the word to be written.
  always_comb begin
    rec_ok_s  = rec_valid(bus.in_class, bus.in_op);
    accept_s  = bus.in_valid && (state_r == S_RUN);
    write_s   = accept_s && (rec_ok_s || NOP_FILL);
    cap_hit_s = write_s && ((count_r + CNT_W'(1)) == MAX_CNT);
    ending_s  = accept_s && (bus.in_last || cap_hit_s);
    if (rec_ok_s) begin
      word_s = encode_word(bus.in_class, bus.in_op, bus.in_rs, bus.in_rt, bus.in_rd, bus.in_imm);
    end else begin
      word_s = 32'h0000_0000;
    end
  end

  // Session FSM next-state logic.
  always_comb begin
    state_n = state_r;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          state_n = S_RUN;
        end else begin
          state_n = S_IDLE;
        end
      end
      S_RUN: begin
        if (ending_s) begin
          state_n = S_FLUSH;
        end else begin
          state_n = S_RUN;
        end
      end
      S_FLUSH: state_n = S_DONE;
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Session FSM state register and status flags decoded from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= S_IDLE;
      in_ready_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_n;
      in_ready_r <= (state_n == S_RUN);
      busy_r     <= (state_n == S_RUN) || (state_n == S_FLUSH);
      done_r     <= (state_n == S_DONE);
    end
  end

  // Write port, address/count tracking and error bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_r    <= BASE;
      count_r   <= '0;
      err_r     <= 8'h00;
      ovf_r     <= 1'b0;
      wr_en_r   <= 1'b0;
      wr_addr_r <= BASE;
      wr_data_r <= 32'h0000_0000;
    end else begin
      wr_en_r <= write_s;
      if ((state_r == S_IDLE) && start) begin
        addr_r    <= BASE;
        count_r   <= '0;
        err_r     <= 8'h00;
        ovf_r     <= 1'b0;
        wr_addr_r <= BASE;
      end else begin
        if (write_s) begin
          wr_addr_r <= addr_r;
          wr_data_r <= word_s;
          addr_r    <= addr_r + ADDR_W'(1);  // wraps modulo 2**ADDR_W
          count_r   <= count_r + CNT_W'(1);
        end
        if (accept_s && !rec_ok_s && (err_r != 8'hFF)) begin
          err_r <= err_r + 8'd1;
        end
        // A record that is both last and capacity-filling ends normally.
        if (cap_hit_s && !bus.in_last) begin
          ovf_r <= 1'b1;
        end
      end
    end
  end

  assign bus.in_ready = in_ready_r;
  assign bus.wr_en    = wr_en_r;
  assign bus.wr_addr  = wr_addr_r;
  assign bus.wr_data  = wr_data_r;
  assign busy         = busy_r;
  assign done         = done_r;
  assign overflow     = ovf_r;
  assign err_count    = err_r;

endmodule

// File: tb/tb_instr_encoder.sv
// ----------------------------------------------------------------------------
// tb_instr_encoder
// Directed bench for instr_encoder (ADDR_W=6, BASE_ADDR=0, MAX_WORDS=4).
// A session-level model tracks acceptance, expected writes (queue with the
// cycle each write must appear), error count, overflow and the done pulse;
// a negedge process compares the DUT against it every cycle. Literal
// expectations pin the encoded words and key timing points.
// ----------------------------------------------------------------------------
module tb_instr_encoder;
  localparam int ADDR_W    = 6;
  localparam int BASE_ADDR = 0;
  localparam int MAX_WORDS = 4;
`ifdef ENC_NOP_FILL_EN
  localparam bit NOP = 1'b1;
`else
  localparam bit NOP = 1'b0;
`endif

  logic       clk;
  logic       reset;
  logic       start;
  logic       busy;
  logic       done;
  logic       overflow;
  logic [7:0] err_count;

  instr_encoder_if #(.ADDR_W(ADDR_W)) bus ();

  instr_encoder #(
    .ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR), .MAX_WORDS(MAX_WORDS)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .bus(bus),
    .busy(busy), .done(done), .overflow(overflow), .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int          due;
    int          addr;
    logic [31:0] data;
  } wr_t;
  wr_t exp_q[$];

  // Model state
  int cyc     = 0;
  bit m_live  = 1'b0;
  bit m_run   = 1'b0;
  int m_end   = -100;   // cycle in which the ending record was accepted
  int m_count = 0;
  int m_err   = 0;
  bit m_ovf   = 1'b0;
  int m_addr  = BASE_ADDR;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  // Reference word from the instruction format tables.
  function automatic logic [31:0] model_word(input int cls, input int op, input int rs,
                                              input int rt, input int rd, input int imm);
    int funct_tab[3] = '{0, 2, 3};
    int opc_tab[2][3] = '{'{8, 35, 43}, '{12, 13, 14}};
    logic [31:0] w;
    if (cls == 0) begin
      w = (32'(rs) << 21) | (32'(rt) << 16) | (32'(rd) << 11) | (32'(imm % 32) << 6) | 32'(funct_tab[op]);
    end else begin
      w = (32'(opc_tab[cls-1][op]) << 26) | (32'(rs) << 21) | (32'(rt) << 16) | 32'(imm % 65536);
    end
    return w;
  endfunction

  // Advance the model by one clock edge using the inputs held across it.
  task automatic model_update();
    int p;
    bit idle;
    bit ok;
    p    = cyc;
    idle = !m_run && (p != m_end + 1) && (p != m_end + 2);
    if (reset) begin
      m_run = 1'b0; m_end = -100; m_err = 0; m_ovf = 1'b0;
      m_count = 0; m_addr = BASE_ADDR; exp_q.delete(); m_live = 1'b1;
    end else if (idle && start) begin
      m_run = 1'b1; m_err = 0; m_ovf = 1'b0; m_count = 0; m_addr = BASE_ADDR;
    end else if (m_run && bus.in_valid) begin
      ok = (bus.in_class != 2'd3) && (bus.in_op != 2'd3);
      if (ok || NOP) begin
        exp_q.push_back('{p + 1, m_addr,
          ok ? model_word(int'(bus.in_class), int'(bus.in_op), int'(bus.in_rs),
                          int'(bus.in_rt), int'(bus.in_rd), int'(bus.in_imm)) : 32'h0});
        m_addr  = (m_addr + 1) % (1 << ADDR_W);
        m_count = m_count + 1;
      end
      if (!ok && m_err < 255) m_err = m_err + 1;
      if (bus.in_last) begin
        m_run = 1'b0; m_end = p;
      end else if (m_count == MAX_WORDS) begin
        m_run = 1'b0; m_end = p; m_ovf = 1'b1;
      end
    end
    cyc = p + 1;
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Present one record for one cycle.
  task automatic send(input logic [1:0] cls, input logic [1:0] op, input logic [4:0] rs,
                      input logic [4:0] rt, input logic [4:0] rd, input logic [15:0] imm,
                      input logic last);
    bus.in_valid = 1'b1; bus.in_class = cls; bus.in_op = op;
    bus.in_rs = rs; bus.in_rt = rt; bus.in_rd = rd; bus.in_imm = imm; bus.in_last = last;
    step();
    bus.in_valid = 1'b0; bus.in_last = 1'b0;
  endtask

  task automatic check_write(input string name, input int addr, input logic [31:0] data);
    check({name, "_wr_en"}, 32'(bus.wr_en), 32'd1);
    check({name, "_addr"}, 32'(bus.wr_addr), 32'(addr));
    check({name, "_data"}, bus.wr_data, data);
  endtask

  // Per-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (m_live) begin
        check("in_ready", 32'(bus.in_ready), 32'(m_run));
        check("busy", 32'(busy), 32'(m_run || (cyc == m_end + 1)));
        check("done", 32'(done), 32'(cyc == m_end + 2));
        check("err_count", 32'(err_count), 32'(m_err));
        check("overflow", 32'(overflow), 32'(m_ovf));
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
          check("wr_en", 32'(bus.wr_en), 32'd1);
          check("wr_addr", 32'(bus.wr_addr), 32'(exp_q[0].addr));
          check("wr_data", bus.wr_data, exp_q[0].data);
          void'(exp_q.pop_front());
        end else begin
          check("wr_en_idle", 32'(bus.wr_en), 32'd0);
        end
      end
    end
  end

  initial begin
    reset = 1'b1; start = 1'b0;
    bus.in_valid = 1'b0; bus.in_class = 2'd0; bus.in_op = 2'd0; bus.in_rs = 5'd0;
    bus.in_rt = 5'd0; bus.in_rd = 5'd0; bus.in_imm = 16'd0; bus.in_last = 1'b0;
    idle_cycles(2);
    reset = 1'b0;
    check("rst_wr_addr", 32'(bus.wr_addr), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    idle_cycles(1);

    // addi rs=0 rt=8 imm=5, not last; then a last record to close the session
    do_start();
    send(2'b01, 2'b00, 5'd0, 5'd8, 5'd0, 16'd5, 1'b0);
    check_write("addi", 0, 32'h20080005);
    send(2'b10, 2'b10, 5'd3, 5'd4, 5'd0, 16'hFFFF, 1'b1);  // xori
    idle_cycles(3);

    // sll rt=8 rd=9 shamt=2; ori rs=8 rt=10 imm=00FF last
    do_start();
    send(2'b00, 2'b00, 5'd0, 5'd8, 5'd9, 16'd2, 1'b0);
    check_write("sll", 0, 32'h00084880);
    send(2'b10, 2'b01, 5'd8, 5'd10, 5'd0, 16'h00FF, 1'b1);
    check_write("ori", 1, 32'h350A00FF);
    step();
    check("done_pulse", 32'(done), 32'd1);
    idle_cycles(2);

    // lw / sw, with a stray start during the session
    do_start();
    start = 1'b1;
    send(2'b01, 2'b01, 5'd29, 5'd8, 5'd0, 16'd4, 1'b0);
    start = 1'b0;
    check_write("lw", 0, 32'h8FA80004);
    send(2'b01, 2'b10, 5'd29, 5'd8, 5'd0, 16'd4, 1'b1);
    check_write("sw", 1, 32'hAFA80004);
    idle_cycles(3);

    // invalid records between valid ones (class 11, then op 3)
    do_start();
    send(2'b01, 2'b00, 5'd1, 5'd2, 5'd0, 16'd7, 1'b0);
    send(2'b11, 2'b00, 5'd1, 5'd2, 5'd0, 16'd7, 1'b0);
    if (NOP) check_write("nop1", 1, 32'h0);
    else     check("inv_no_wr", 32'(bus.wr_en), 32'd0);
    send(2'b00, 2'b11, 5'd1, 5'd2, 5'd3, 16'd1, 1'b0);
    send(2'b10, 2'b01, 5'd8, 5'd10, 5'd0, 16'h00FF, 1'b1);
    if (NOP) check_write("after_nop", 3, 32'h350A00FF);
    else     check_write("after_inv", 1, 32'h350A00FF);
    check("inv_err", 32'(err_count), 32'd2);
    check("inv_no_ovf", 32'(overflow), 32'd0);
    idle_cycles(3);

    // capacity: six records offered, four accepted
    do_start();
    for (int i = 0; i < 6; i++) begin
      send(2'b01, 2'b00, 5'd1, 5'd2, 5'd0, 16'(i), 1'b0);
      if (i == 3) begin
        check("cap_ready", 32'(bus.in_ready), 32'd0);
        check("cap_ovf", 32'(overflow), 32'd1);
        check_write("cap_last", 3, 32'h20220003);
      end
      if (i == 4) check("cap_done", 32'(done), 32'd1);
    end
    idle_cycles(2);

    // reset in the cycle after an accept, with another record presented
    do_start();
    send(2'b11, 2'b01, 5'd0, 5'd0, 5'd0, 16'd0, 1'b0);
    send(2'b01, 2'b00, 5'd0, 5'd8, 5'd0, 16'd5, 1'b0);
    bus.in_valid = 1'b1; bus.in_class = 2'b01; bus.in_op = 2'b00; bus.in_imm = 16'd9;
    reset = 1'b1;
    step();
    reset = 1'b0; bus.in_valid = 1'b0;
    check("rst_mid_wr_en", 32'(bus.wr_en), 32'd0);
    check("rst_mid_ready", 32'(bus.in_ready), 32'd0);
    check("rst_mid_addr", 32'(bus.wr_addr), 32'd0);
    check("rst_mid_err", 32'(err_count), 32'd0);
    idle_cycles(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
